execute_cc_mreg: RTL and testbench

- Back half of the Execute stage; consumes the 64-bit ALU result (valE) and overflow flag.
- Holds the condition-code register (ZF/SF/OF) and evaluates Cnd for jXX/cmovXX.
- Squashes cmov destinations and drives the E-to-M pipeline register feeding the Memory stage.
- Pipeline control supplies M_stall/M_bubble; e_Cnd feeds branch-mispredict detection.

---
 rtl/execute_cc_mreg.sv | 124 ++++++++++++
 tb/tb_execute_cc_mreg.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_cc_mreg.sv
// rtl/execute_cc_mreg.sv - Execute back half: condition codes, Cnd evaluation, cmov squash, E-to-M register
module execute_cc_mreg #(
    parameter int         DATA_W = 64,
    parameter logic [2:0] CC_RST = 3'b100
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        E_stat,
    input  logic [3:0]        E_icode,
    input  logic [3:0]        E_ifun,
    input  logic [DATA_W-1:0] E_valA,
    input  logic [3:0]        E_dstE,
    input  logic [3:0]        E_dstM,
    input  logic [DATA_W-1:0] alu_valE,
    input  logic              alu_overflow,
    input  logic [2:0]        m_stat,
    input  logic [2:0]        W_stat,
    input  logic              M_stall,
    input  logic              M_bubble,
    output logic              e_Cnd,
    output logic [3:0]        e_dstE,
    output logic [DATA_W-1:0] e_valE,
    output logic [2:0]        cc_out,
    output logic [2:0]        M_stat,
    output logic [3:0]        M_icode,
    output logic              M_Cnd,
    output logic [DATA_W-1:0] M_valE,
    output logic [DATA_W-1:0] M_valA,
    output logic [3:0]        M_dstE,
    output logic [3:0]        M_dstM
);
    localparam logic [3:0] I_NOP  = 4'h1;
    localparam logic [3:0] I_CMOV = 4'h2;
    localparam logic [3:0] I_OPQ  = 4'h6;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] R_NONE = 4'hF;
    localparam logic [2:0] S_AOK  = 3'd1;
    localparam logic [2:0] S_HLT  = 3'd2;
    localparam logic [2:0] S_ADR  = 3'd3;
    localparam logic [2:0] S_INS  = 3'd4;

    logic [2:0]        r_cc;
    logic              w_zf, w_sf, w_of;
    logic              w_cnd;
    logic              w_m_exc, w_w_exc, w_set_cc;

    logic [2:0]        r_m_stat;
    logic [3:0]        r_m_icode;
    logic              r_m_cnd;
    logic [DATA_W-1:0] r_m_vale;
    logic [DATA_W-1:0] r_m_vala;
    logic [3:0]        r_m_dste;
    logic [3:0]        r_m_dstm;

    assign {w_zf, w_sf, w_of} = r_cc;

    // An older instruction that faulted downstream must not leave its successors' flags visible
    assign w_m_exc  = (m_stat == S_HLT) || (m_stat == S_ADR) || (m_stat == S_INS);
    assign w_w_exc  = (W_stat == S_HLT) || (W_stat == S_ADR) || (W_stat == S_INS);
    assign w_set_cc = (E_icode == I_OPQ) && !w_m_exc && !w_w_exc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cc <= CC_RST;
        end else if (w_set_cc) begin
            r_cc <= {(alu_valE == '0), alu_valE[DATA_W-1], alu_overflow};
        end
    end

    always_comb begin
        w_cnd = 1'b0;
        case (E_ifun)
            4'h0:    w_cnd = 1'b1;
            4'h1:    w_cnd = (w_sf ^ w_of) | w_zf;
            4'h2:    w_cnd = w_sf ^ w_of;
            4'h3:    w_cnd = w_zf;
            4'h4:    w_cnd = ~w_zf;
            4'h5:    w_cnd = ~(w_sf ^ w_of);
            4'h6:    w_cnd = ~(w_sf ^ w_of) & ~w_zf;
            default: w_cnd = 1'b0;
        endcase
    end

    assign e_Cnd  = ((E_icode == I_CMOV) || (E_icode == I_JXX)) ? w_cnd : 1'b0;
    assign e_dstE = ((E_icode == I_CMOV) && !w_cnd) ? R_NONE : E_dstE;
    assign e_valE = alu_valE;
    assign cc_out = r_cc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m_stat  <= S_AOK;
            r_m_icode <= I_NOP;
            r_m_cnd   <= 1'b0;
            r_m_vale  <= '0;
            r_m_vala  <= '0;
            r_m_dste  <= R_NONE;
            r_m_dstm  <= R_NONE;
        end else if (M_bubble) begin
            r_m_stat  <= S_AOK;
            r_m_icode <= I_NOP;
            r_m_cnd   <= 1'b0;
            r_m_vale  <= '0;
            r_m_vala  <= '0;
            r_m_dste  <= R_NONE;
            r_m_dstm  <= R_NONE;
        end else if (!M_stall) begin
            r_m_stat  <= E_stat;
            r_m_icode <= E_icode;
            r_m_cnd   <= e_Cnd;
            r_m_vale  <= alu_valE;
            r_m_vala  <= E_valA;
            r_m_dste  <= e_dstE;
            r_m_dstm  <= E_dstM;
        end
    end

    assign M_stat  = r_m_stat;
    assign M_icode = r_m_icode;
    assign M_Cnd   = r_m_cnd;
    assign M_valE  = r_m_vale;
    assign M_valA  = r_m_vala;
    assign M_dstE  = r_m_dste;
    assign M_dstM  = r_m_dstm;
endmodule

// File: tb/tb_execute_cc_mreg.sv
// tb/tb_execute_cc_mreg.sv - directed self-checking bench for execute_cc_mreg
module tb_execute_cc_mreg;
    localparam int DATA_W = 64;
    localparam logic [63:0] MSB = 64'h8000_0000_0000_0000;

    logic              clk;
    logic              reset_n;
    logic [2:0]        E_stat;
    logic [3:0]        E_icode;
    logic [3:0]        E_ifun;
    logic [DATA_W-1:0] E_valA;
    logic [3:0]        E_dstE;
    logic [3:0]        E_dstM;
    logic [DATA_W-1:0] alu_valE;
    logic              alu_overflow;
    logic [2:0]        m_stat;
    logic [2:0]        W_stat;
    logic              M_stall;
    logic              M_bubble;
    logic              e_Cnd;
    logic [3:0]        e_dstE;
    logic [DATA_W-1:0] e_valE;
    logic [2:0]        cc_out;
    logic [2:0]        M_stat;
    logic [3:0]        M_icode;
    logic              M_Cnd;
    logic [DATA_W-1:0] M_valE;
    logic [DATA_W-1:0] M_valA;
    logic [3:0]        M_dstE;
    logic [3:0]        M_dstM;

    int n_chk = 0;
    int n_bad = 0;

    execute_cc_mreg #(.DATA_W(DATA_W), .CC_RST(3'b100)) dut (
        .clk(clk), .reset_n(reset_n),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valA(E_valA),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .alu_valE(alu_valE), .alu_overflow(alu_overflow),
        .m_stat(m_stat), .W_stat(W_stat), .M_stall(M_stall), .M_bubble(M_bubble),
        .e_Cnd(e_Cnd), .e_dstE(e_dstE), .e_valE(e_valE), .cc_out(cc_out),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE),
        .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic opq(input logic [63:0] vale, input logic ovf);
        E_icode = 4'h6; E_ifun = 4'h0; alu_valE = vale; alu_overflow = ovf;
    endtask

    // Condition table written out per jump/cmov mnemonic
    function automatic logic cnd_ref(input logic [3:0] fn, input logic [2:0] cc);
        logic zf, sf, of;
        {zf, sf, of} = cc;
        case (fn)
            4'd0: return 1'b1;
            4'd1: return (sf != of) || zf;
            4'd2: return sf != of;
            4'd3: return zf;
            4'd4: return !zf;
            4'd5: return sf == of;
            4'd6: return (sf == of) && !zf;
            default: return 1'b0;
        endcase
    endfunction

    logic [63:0] sw_vale [6] = '{64'h0, 64'h0, 64'h1, 64'h1, MSB, MSB};
    logic        sw_ovf  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  sw_cc   [6] = '{3'b100, 3'b101, 3'b000, 3'b001, 3'b010, 3'b011};

    initial begin
        reset_n = 1'b0; E_stat = 3'd1; E_icode = 4'h1; E_ifun = 4'h0; E_valA = '0;
        E_dstE = 4'hF; E_dstM = 4'hF; alu_valE = '0; alu_overflow = 1'b0;
        m_stat = 3'd1; W_stat = 3'd1; M_stall = 1'b0; M_bubble = 1'b0;
        #12;
        check("rst_cc", cc_out, 3'b100);
        check("rst_mstat", M_stat, 3'd1);
        check("rst_micode", M_icode, 4'h1);
        check("rst_mcnd", M_Cnd, 1'b0);
        check("rst_mvale", M_valE, 64'h0);
        check("rst_mvala", M_valA, 64'h0);
        check("rst_mdste", M_dstE, 4'hF);
        check("rst_mdstm", M_dstM, 4'hF);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // OPq sequence and M load
        opq(64'h0, 1'b0); E_valA = 64'h1234; E_dstE = 4'h3; E_dstM = 4'hF;
        #1;
        check("evale_pass", e_valE, 64'h0);
        step();
        check("cc_zero", cc_out, 3'b100);
        check("m_icode_opq", M_icode, 4'h6);
        check("m_vala_opq", M_valA, 64'h1234);
        check("m_dste_opq", M_dstE, 4'h3);
        check("m_cnd_opq", M_Cnd, 1'b0);
        opq(64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        step();
        check("cc_neg", cc_out, 3'b010);
        check("m_vale_opq", M_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        opq(MSB, 1'b1);
        step();
        check("cc_msb_ovf", cc_out, 3'b011);

        // cmov with ZF=0 is squashed, with ZF=1 writes
        E_icode = 4'h2; E_ifun = 4'h3; E_dstE = 4'h5; alu_valE = 64'h77;
        #1;
        check("cmov_ecnd0", e_Cnd, 1'b0);
        check("cmov_edste_sq", e_dstE, 4'hF);
        step();
        check("cmov_mdste_sq", M_dstE, 4'hF);
        check("cmov_mcnd0", M_Cnd, 1'b0);
        check("cmov_cc_keep", cc_out, 3'b011);
        opq(64'h0, 1'b0);
        step();
        E_icode = 4'h2; E_ifun = 4'h3; E_dstE = 4'h5;
        #1;
        check("cmov_ecnd1", e_Cnd, 1'b1);
        check("cmov_edste", e_dstE, 4'h5);
        step();
        check("cmov_mdste", M_dstE, 4'h5);
        check("cmov_mcnd1", M_Cnd, 1'b1);

        // No same-cycle bypass of new flags
        opq(64'h1, 1'b0);
        #1;
        check("nobypass_pre", cc_out, 3'b100);
        step();
        check("nobypass_post", cc_out, 3'b000);

        // Exception gating
        opq(64'h0, 1'b0); m_stat = 3'd3;
        step();
        check("gate_mstat", cc_out, 3'b000);
        m_stat = 3'd1; W_stat = 3'd2;
        step();
        check("gate_wstat", cc_out, 3'b000);
        W_stat = 3'd1;
        step();
        check("gate_open", cc_out, 3'b100);
        E_stat = 3'd3; opq(MSB, 1'b0);
        step();
        check("estat_exc_cc", cc_out, 3'b010);
        check("estat_exc_m", M_stat, 3'd3);
        E_stat = 3'd1;

        // jXX decode sweep over every reachable flag combination
        for (int s = 0; s < 6; s++) begin
            opq(sw_vale[s], sw_ovf[s]);
            step();
            check($sformatf("sweep_cc%0d", s), cc_out, sw_cc[s]);
            E_icode = 4'h7;
            for (int f = 0; f < 16; f++) begin
                E_ifun = f[3:0];
                #1;
                check($sformatf("jxx_cc%b_f%0d", sw_cc[s], f), e_Cnd, cnd_ref(f[3:0], sw_cc[s]));
            end
        end
        E_icode = 4'h0; E_ifun = 4'h0;
        #1;
        check("ecnd_other_icode", e_Cnd, 1'b0);

        // Stall and bubble
        E_icode = 4'h7; E_ifun = 4'h0; E_valA = 64'hAA; alu_valE = 64'hBB; E_dstE = 4'hF; E_dstM = 4'hF;
        step();
        check("jmp_m_cnd", M_Cnd, 1'b1);
        M_stall = 1'b1;
        opq(64'h0, 1'b0); E_valA = 64'hCC; E_dstE = 4'h2; E_dstM = 4'h4;
        step();
        step();
        check("stall_icode", M_icode, 4'h7);
        check("stall_vale", M_valE, 64'hBB);
        check("stall_vala", M_valA, 64'hAA);
        check("stall_cnd", M_Cnd, 1'b1);
        check("stall_cc_upd", cc_out, 3'b100);
        M_bubble = 1'b1;
        step();
        check("bub_icode", M_icode, 4'h1);
        check("bub_stat", M_stat, 3'd1);
        check("bub_vale", M_valE, 64'h0);
        check("bub_dste", M_dstE, 4'hF);
        M_stall = 1'b0; M_bubble = 1'b0;
        step();
        check("load_after", M_valA, 64'hCC);
        check("load_dstm", M_dstM, 4'h4);
        opq(64'h1, 1'b0);
        step();
        check("pre_rst_cc", cc_out, 3'b000);

        // Asynchronous reset mid-cycle with stall pending
        M_stall = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_cc", cc_out, 3'b100);
        check("arst_icode", M_icode, 4'h1);
        check("arst_dste", M_dstE, 4'hF);
        check("arst_vale", M_valE, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("post_rst_hold", M_icode, 4'h1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
